vram_ctrl: RTL and testbench
============================

// Module: vram_ctrl
// PURPOSE
//  Owns the single-port frame memory (VRAM) and shares it between the VGA scan-out read path
//  and the SPI command write path. It decodes committed SPI commands (WRITE_CELL, SET_SCORE,
//  CLEAR) and queues cell writes. VGA reads always win the port; writes drain only in idle cycles.
//  It also holds the score register fed to vga_top. Sits between spi/spi_decoder and vga_top in top.
// PARAMETERS
//  ADDR_W      10    VRAM address width (matches vga_top raddr)
//  DATA_W      3     VRAM cell width ({R,G,B})
//  DEPTH       1000  number of valid cells; CLEAR walks 0..DEPTH-1
//  FIFO_DEPTH  4     write-queue entries (power of 2)
// PORTS
//  clk        in   1       system clock (PLL global clock)
//  reset      in   1       asynchronous, active-high reset
//  cmd_valid  in   1       1-cycle pulse: command/databyte1/databyte2 stable and valid this cycle
//  command    in   8       opcode: 8'h01 WRITE_CELL, 8'h02 SET_SCORE, 8'h03 CLEAR, others ignored
//  databyte1  in   8       [7:5] colour, [1:0] addr/score MSBs
//  databyte2  in   8       addr/score LSBs
//  re         in   1       VGA read request this cycle
//  raddr      in   ADDR_W  VGA read address
//  rdata      out  DATA_W  read data to VGA (= mem_rdata)
//  rvalid     out  1       rdata valid (re delayed one cycle)
//  score      out  10      current score
//  busy       out  1       CLEAR in progress or write queue non-empty
//  overflow   out  1       sticky: a WRITE_CELL was dropped on a full queue
//  mem_addr   out  ADDR_W  VRAM address
//  mem_we     out  1       VRAM write enable
//  mem_wdata  out  DATA_W  VRAM write data
//  mem_rdata  in   DATA_W  VRAM read data, valid one cycle after a read access
// BEHAVIOUR
//  Reset (async): state IDLE, queue empty, clr_addr 0, score 0, overflow 0, rvalid 0.
//   Outputs derived from state, so mem_we 0 and busy 0 while reset is high.
//  Decode on cmd_valid; addr/value = {databyte1[1:0], databyte2}:
//   WRITE_CELL: push {addr, databyte1[7:5]}. If full and no pop that cycle -> drop, overflow<=1.
//    Push+pop in same cycle when full is accepted; count unchanged.
//   SET_SCORE: score <= value on the next edge; applies in any state.
//   CLEAR: clr_colour <= databyte1[7:5], clr_addr <= 0, state <= CLEAR.
//    CLEAR issued during CLEAR restarts from 0 with the new colour.
//   Unknown opcode: no effect.
//  Port mux, combinational each cycle:
//   re=1: mem_addr=raddr, mem_we=0. No write side advances.
//   re=0, CLEAR: mem_addr=clr_addr, mem_wdata=clr_colour, mem_we=1, clr_addr++.
//    Write issued at clr_addr=DEPTH-1 -> state IDLE, clr_addr 0.
//   re=0, IDLE, queue non-empty: write head entry, mem_we=1, pop.
//   Otherwise mem_we=0, mem_addr=raddr.
//  CLEAR has priority over the queue. Queued writes drain after CLEAR, so they land on the cleared screen.
//  Queue is FIFO: writes to VRAM occur in command order.
//  rvalid <= re each cycle. rdata passes through mem_rdata, so read latency is exactly 1 cycle.
//  Read-after-write to same address in consecutive cycles returns the new data (VRAM write-first).
//  busy = (state==CLEAR) | (count!=0). overflow clears only on reset.
//  Reset mid-CLEAR or mid-drain: abandons the operation and empties the queue. VRAM contents are left as-is.
// TESTING
//  1. reset; re=0; WRITE_CELL databyte1=8'hA1, databyte2=8'h23 -> next cycle mem_we=1, mem_addr=10'h123, mem_wdata=3'b101.
//  2. re held 1 for 8 cycles; 3 WRITE_CELLs queued -> mem_we=0 for those 8 cycles, busy=1.
//     After re drops: 3 writes in consecutive cycles, in order; then busy=0.
//  3. 5 WRITE_CELLs with re=1 throughout -> 4 queued, 5th dropped, overflow=1; overflow stays 1 until reset.
//  4. CLEAR colour 3'b010, re=0 -> DEPTH consecutive writes addr 0..999, then IDLE.
//     Repeat with re toggling every cycle -> same writes complete in ~2*DEPTH cycles.
//  5. SET_SCORE databyte1=8'h03, databyte2=8'hE7 -> score=10'd999 next cycle, including mid-CLEAR.
//  6. assert reset at clr_addr=500 -> mem_we=0 and busy=0 immediately; score=0.
//     re=1 with raddr=5 -> rvalid=1 one cycle later, rdata equals the mem_rdata model.

Source files
------------

// File: rtl/vram_ctrl.sv
// VRAM port arbiter: VGA scan-out reads always win; SPI cell writes and CLEAR fills
// use the idle cycles, and writes reach VRAM in command order.
module vram_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 3,
    parameter int DEPTH      = 1000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [7:0]        command,
    input  logic [7:0]        databyte1,
    input  logic [7:0]        databyte2,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [9:0]        score,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [7:0] OP_WRITE_CELL = 8'h01;
    localparam logic [7:0] OP_SET_SCORE  = 8'h02;
    localparam logic [7:0] OP_CLEAR      = 8'h03;

    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] clr_colour_q, clr_colour_d;
    logic [9:0]        score_q, score_d;
    logic              overflow_q, overflow_d;
    logic              rvalid_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [9:0]        cmd_value;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_colour;
    logic              is_write, full, push, pop;
    logic              unused_bits;

    assign cmd_value   = {databyte1[1:0], databyte2};
    assign cmd_addr    = ADDR_W'(cmd_value);
    assign cmd_colour  = DATA_W'(databyte1[7:5]);
    assign unused_bits = ^databyte1[4:2];

    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign is_write = cmd_valid && (command == OP_WRITE_CELL);
    // A full queue still accepts a push when the head drains in the same cycle.
    assign push     = is_write && (!full || pop);

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        clr_colour_d = clr_colour_q;
        score_d      = score_q;
        overflow_d   = overflow_q;
        mem_addr     = raddr;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        pop          = 1'b0;

        if (!re) begin
            if (state_q == ST_CLEAR) begin
                mem_addr  = clr_addr_q;
                mem_wdata = clr_colour_q;
                mem_we    = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end else if (count_q != '0) begin
                mem_addr  = fifo_addr_q[rd_ptr_q];
                mem_wdata = fifo_data_q[rd_ptr_q];
                mem_we    = 1'b1;
                pop       = 1'b1;
            end
        end

        if (is_write && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (cmd_valid && (command == OP_SET_SCORE)) begin
            score_d = cmd_value;
        end
        // A new CLEAR overrides the walk in progress and restarts it from address 0.
        if (cmd_valid && (command == OP_CLEAR)) begin
            state_d      = ST_CLEAR;
            clr_addr_d   = '0;
            clr_colour_d = cmd_colour;
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            clr_addr_q   <= '0;
            clr_colour_q <= '0;
            score_q      <= '0;
            overflow_q   <= 1'b0;
            rvalid_q     <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            clr_colour_q <= clr_colour_d;
            score_q      <= score_d;
            overflow_q   <= overflow_d;
            rvalid_q     <= re;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cmd_addr;
            fifo_data_q[wr_ptr_q] <= cmd_colour;
        end
    end

    assign rdata     = mem_rdata;
    assign rvalid    = rvalid_q;
    assign score     = score_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q == ST_CLEAR) || (count_q != '0);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl with a write-first VRAM model hanging off the memory port.
module tb_vram_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 1000;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic [7:0]        command, databyte1, databyte2;
    logic              re;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [9:0]        score;
    logic              busy, overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] vram [1024];

    vram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .command(command),
        .databyte1(databyte1), .databyte2(databyte2), .re(re), .raddr(raddr),
        .rdata(rdata), .rvalid(rvalid), .score(score), .busy(busy), .overflow(overflow),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : vram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [7:0] b1, input logic [7:0] b2);
        cmd_valid = 1'b1;
        command   = c;
        databyte1 = b1;
        databyte2 = b2;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_cell(input logic [9:0] a, input logic [2:0] col);
        send_cmd(8'h01, {col, 3'b000, a[9:8]}, a[7:0]);
    endtask

    // Expects every entry of exp_q to be written on consecutive cycles starting now.
    task automatic drain(input string tag);
        int bad = 0;
        int gaps = 0;
        int cyc = 0;
        logic [ADDR_W+DATA_W-1:0] e;
        while (exp_q.size() > 0 && cyc < 20) begin
            #1;
            if (mem_we) begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) bad++;
            end else begin
                gaps++;
            end
            tick();
            cmd_valid = 1'b0;
            cyc++;
        end
        chk({tag, "_order"}, bad, 0);
        chk({tag, "_gaps"}, gaps, 0);
        chk({tag, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int n, n2, bad, cyc, restarted;
        for (int i = 0; i < 1024; i++) vram[i] = '0;
        reset = 1'b1; cmd_valid = 1'b0; command = '0; databyte1 = '0; databyte2 = '0;
        re = 1'b0; raddr = '0;

        // Reset state
        #2;
        chk("rst_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_score", score, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_rvalid", rvalid, 0);
        tick();
        reset = 1'b0;

        // Single WRITE_CELL lands the next cycle
        send_cmd(8'h01, 8'hA1, 8'h23);
        #1;
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 10'h123);
        chk("t1_wdata", mem_wdata, 3'b101);
        tick();
        chk("t1_idle", busy, 0);

        // Reads hold off three queued writes for 8 cycles
        re = 1'b1; raddr = 10'h1F0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_valid = (i < 3);
            command = 8'h01;
            case (i)
                0: begin databyte1 = 8'h62; databyte2 = 8'hAA; end
                1: begin databyte1 = 8'hC0; databyte2 = 8'h55; end
                default: begin databyte1 = 8'h23; databyte2 = 8'hFF; end
            endcase
            #1;
            if (mem_we !== 1'b0 || mem_addr !== raddr) bad++;
            if (i > 0 && busy !== 1'b1) bad++;
            tick();
        end
        cmd_valid = 1'b0;
        chk("t2_blocked", bad, 0);
        re = 1'b0;
        exp_q.push_back({10'h2AA, 3'b011});
        exp_q.push_back({10'h055, 3'b110});
        exp_q.push_back({10'h3FF, 3'b001});
        drain("t2");
        chk("t2_busy_end", busy, 0);

        // Overflow on a fifth write to a full queue
        re = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("t3_ovf_before", overflow, 0);
            push_cell(10'h010 + 10'(i), 3'(i + 1));
        end
        #1;
        chk("t3_ovf", overflow, 1);
        chk("t3_busy", busy, 1);
        re = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back({10'h010 + 10'(i), 3'(i + 1)});
        drain("t3");
        chk("t3_no_fifth", mem_we, 0);
        chk("t3_ovf_sticky", overflow, 1);

        // Push and pop together on a full queue: accepted
        re = 1'b1;
        for (int i = 0; i < 4; i++) push_cell(10'h020 + 10'(i), 3'b111);
        re = 1'b0;
        cmd_valid = 1'b1; command = 8'h01; databyte1 = 8'hA0; databyte2 = 8'h24;
        for (int i = 0; i < 4; i++) exp_q.push_back({10'h020 + 10'(i), 3'b111});
        exp_q.push_back({10'h024, 3'b101});
        drain("t3_full_pp");

        // Unknown opcode does nothing; SET_SCORE in IDLE
        send_cmd(8'h07, 8'hA1, 8'h23);
        #1;
        chk("unk_we", mem_we, 0);
        chk("unk_busy", busy, 0);
        send_cmd(8'h02, 8'h01, 8'h55);
        #1;
        chk("t5_score_idle", score, 10'h155);

        // CLEAR with re=0: DEPTH back-to-back writes
        send_cmd(8'h03, 8'h40, 8'h00);
        n = 0; bad = 0; cyc = 0;
        while (n < DEPTH && cyc < DEPTH + 50) begin
            #1;
            if (mem_we) begin
                if (mem_addr !== ADDR_W'(n) || mem_wdata !== 3'b010) bad++;
                n++;
            end
            tick();
            cyc++;
        end
        chk("t4_count", n, DEPTH);
        chk("t4_data", bad, 0);
        chk("t4_cycles", cyc, DEPTH);
        chk("t4_busy_end", busy, 0);
        chk("t4_state_end", dbg_state, 0);

        // CLEAR with re toggling, plus SET_SCORE mid-CLEAR
        send_cmd(8'h03, 8'h40, 8'h00);
        n = 0; bad = 0; cyc = 0;
        while (n < DEPTH && cyc < 2 * DEPTH + 50) begin
            re = cyc[0];
            cmd_valid = (cyc == 100);
            command = 8'h02; databyte1 = 8'h03; databyte2 = 8'hE7;
            #1;
            if (cyc == 101) begin
                chk("t5_score_clear", score, 10'd999);
                chk("t5_busy_clear", busy, 1);
            end
            if (mem_we) begin
                if (re || mem_addr !== ADDR_W'(n) || mem_wdata !== 3'b010) bad++;
                n++;
            end
            tick();
            cyc++;
        end
        re = 1'b0; cmd_valid = 1'b0;
        chk("t4b_count", n, DEPTH);
        chk("t4b_data", bad, 0);
        chk("t4b_cycles_ok", (cyc >= 2 * DEPTH - 1) && (cyc <= 2 * DEPTH + 1), 1);
        #1;
        chk("t4b_busy_end", busy, 0);
        tick();

        // CLEAR restarted mid-walk, then reset at clr_addr=500
        send_cmd(8'h03, 8'hA0, 8'h00);
        n = 0; n2 = 0; bad = 0; cyc = 0; restarted = 0;
        while (n2 < 500 && cyc < 1000) begin
            cmd_valid = (!restarted && n == 200);
            command = 8'h03; databyte1 = 8'hE0; databyte2 = 8'h00;
            #1;
            if (mem_we) begin
                if (restarted) begin
                    if (mem_addr !== ADDR_W'(n2) || mem_wdata !== 3'b111) bad++;
                    n2++;
                end else begin
                    n++;
                end
            end
            if (cmd_valid) restarted = 1;
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        chk("t6_restart_writes", n2, 500);
        chk("t6_restart_data", bad, 0);
        reset = 1'b1;
        #1;
        chk("t6_rst_we", mem_we, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_score", score, 0);
        chk("t6_rst_ovf", overflow, 0);
        tick();
        reset = 1'b0;
        re = 1'b1; raddr = 10'd5;
        #1;
        chk("t6_rvalid_pre", rvalid, 0);
        tick();
        chk("t6_rvalid", rvalid, 1);
        chk("t6_rdata5", rdata, 3'b111);
        raddr = 10'd700;
        tick();
        chk("t6_rdata700", rdata, 3'b010);
        re = 1'b0;
        tick();
        chk("t6_rvalid_drop", rvalid, 0);

        // Read right after a queued write returns the new data
        push_cell(10'h077, 3'b110);
        #1;
        chk("raw_we", mem_we, 1);
        tick();
        re = 1'b1; raddr = 10'h077;
        tick();
        chk("raw_rdata", rdata, 3'b110);
        re = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
